// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled UART RX with a held byte, rda handshake and sticky error flags.
// Define SPART_RX_MAJORITY_EN to take each bit decision from a 2-of-3 vote over ticks 7, 8 and 9.
`timescale 1ns/1ps
module spart_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] brg_div,
  input  logic        rd_ack,
  output logic [7:0]  rx_data,
  output logic        rda,
  output logic        framing_err,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

`ifdef SPART_RX_MAJORITY_EN
  localparam logic [3:0] START_LAST = 4'd8;
`else
  localparam logic [3:0] START_LAST = 4'd7;
`endif
  localparam logic [3:0] BIT_LAST = 4'd15;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] valid_q;
  logic                   rxs;
  logic                   rxs_hi_q;
  logic [15:0]            brg_cnt_q, brg_cnt_d;
  logic                   tick;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [3:0]             bit_last;
  logic                   fire;
  logic                   sample;
  logic                   done_ok, done_bad, load;
  logic [7:0]             rx_data_d;
  logic                   rda_d, framing_err_d, overrun_d;

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign tick     = (brg_cnt_q == 16'd0);
  assign bit_last = (state_q == START) ? START_LAST : BIT_LAST;
  assign fire     = tick && (tick_cnt_q == bit_last);

  // Synchronizer; rxs_hi_q only arms once the chain holds real line samples, so a
  // line held low through reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '1;
      valid_q  <= '0;
      rxs_hi_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
      valid_q  <= {valid_q[SYNC_STAGES-2:0], 1'b1};
      rxs_hi_q <= valid_q[SYNC_STAGES-1] & rxs;
    end
  end

`ifdef SPART_RX_MAJORITY_EN
  logic maj_a_q, maj_b_q;

  // Captures the two samples preceding the decision tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maj_a_q <= 1'b1;
      maj_b_q <= 1'b1;
    end else if (tick) begin
      if (tick_cnt_q == bit_last - 4'd2) maj_a_q <= rxs;
      if (tick_cnt_q == bit_last - 4'd1) maj_b_q <= rxs;
    end
  end

  assign sample = (maj_a_q & maj_b_q) | (maj_a_q & rxs) | (maj_b_q & rxs);
`else
  assign sample = rxs;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      brg_cnt_q   <= 16'd0;
      tick_cnt_q  <= 4'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data     <= 8'h00;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      brg_cnt_q   <= brg_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data     <= rx_data_d;
      rda         <= rda_d;
      framing_err <= framing_err_d;
      overrun     <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    brg_cnt_d  = tick ? brg_div : brg_cnt_q - 16'd1;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    done_ok    = 1'b0;
    done_bad   = 1'b0;

    case (state_q)
      IDLE: begin
        tick_cnt_d = 4'd0;
        bit_idx_d  = 3'd0;
        if (rxs_hi_q && !rxs) begin
          state_d   = START;
          brg_cnt_d = brg_div;
        end
      end
      START: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (fire) begin
            tick_cnt_d = 4'd0;
            state_d    = sample ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (fire) begin
            shift_d   = {sample, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (fire) begin
            state_d  = IDLE;
            done_ok  = sample;
            done_bad = !sample;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An ack in the completion cycle frees the holding slot for the new byte.
    load          = done_ok && (!rda || rd_ack);
    rx_data_d     = load ? shift_q : rx_data;
    rda_d         = load || (rda && !rd_ack);
    overrun_d     = (done_ok && rda && !rd_ack) || (overrun && !rd_ack);
    framing_err_d = done_bad || (framing_err && !rd_ack);
  end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops in the rxd synchronizer (legal 2..4).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-005 brg_div  input  16  baud divisor; one oversample tick every brg_div+1 clk cycles, 16 ticks per bit.
REQ-006 rd_ack  input  1  one-cycle pulse from bus side; consumes the held byte.
REQ-007 rx_data  output  8  last good received byte, held until overwritten.
REQ-008 rda  output  1  receive data available; high while rx_data holds an unconsumed byte.
REQ-009 framing_err  output  1  sticky; stop bit sampled low.
REQ-010 overrun  output  1  sticky; byte completed while rda was high.

Function
REQ-011 rxd SHALL pass through SYNC_STAGES flops (reset value 1); all logic below SHALL use only the synchronized value rxs.
REQ-012 Tick generator SHALL be a 16-bit down counter: reload with brg_div when zero and assert tick for that cycle, else decrement; brg_div=0 gives a tick every clk.
REQ-013 A brg_div change SHALL take effect at the next reload only, with no mid-count truncation.
REQ-014 FSM SHALL have states IDLE, START, DATA, STOP; a 4-bit tick counter and a 3-bit bit index count within states.
REQ-015 IDLE: a rxs 1->0 transition SHALL move to START and clear the tick counter; the tick generator SHALL also reload, aligning sampling to the edge.
REQ-016 START: on the 8th tick, rxs=0 SHALL move to DATA with tick counter cleared; rxs=1 SHALL be a false start, return to IDLE, no flags changed.
REQ-017 DATA: a bit SHALL be sampled on every 16th tick into a shift register, LSB first; after bit 7 it SHALL move to STOP.
REQ-018 STOP: on the 16th tick, rxs=1 SHALL complete the frame; rxs=0 SHALL set framing_err, discard the byte and leave rx_data/rda unchanged; both cases return to IDLE.
REQ-019 Frame completion with rda=0 SHALL load rx_data and set rda in the clk after the stop-sample tick.
REQ-020 Frame completion with rda=1 SHALL set overrun, keep the old rx_data and keep rda=1; the new byte is dropped.
REQ-021 rd_ack with rda=1 SHALL clear rda next cycle; rd_ack with rda=0 SHALL be ignored.
REQ-022 rd_ack in the same cycle as a completion SHALL clear the old byte and accept the new one: rda stays 1, rx_data takes the new byte, no overrun.
REQ-023 rd_ack SHALL also clear framing_err and overrun, unless the same condition is set again in that cycle, in which case set wins.
REQ-024 A new frame's start edge SHALL be accepted in the IDLE cycle straight after STOP, so back-to-back frames with one stop bit are received.

Reset
REQ-025 rst high SHALL asynchronously force IDLE, tick counter 0, bit index 0, down counter 0, synchronizer flops 1, shift register 0, rx_data=0x00, rda=0, framing_err=0, overrun=0.
REQ-026 rst asserted mid-frame SHALL abandon the frame, and no flag or data SHALL reflect the partial byte after release.
REQ-027 After rst release with rxd held low, no start SHALL be detected until rxs has been seen high then low.

Configuration
REQ-028 Macro SPART_RX_MAJORITY_EN defined: every start, data and stop sample SHALL be the 2-of-3 majority of rxs at ticks 7, 8 and 9 of the bit, and the decision SHALL act at tick 9.
REQ-029 SPART_RX_MAJORITY_EN undefined: a single rxs sample at tick 8 SHALL be used, and the majority logic SHALL not be built.

Verification
REQ-030 brg_div=0x0001, frame 0xA5 with one stop bit (32 clk per bit) -> rda=1 and rx_data=0xA5 one clk after the stop-sample tick; framing_err=0, overrun=0.
REQ-031 rxd low for 4 ticks then high, brg_div=0x0000 -> FSM back in IDLE, rda=0, no flags set.
REQ-032 Frame 0x3C with stop bit driven low -> framing_err=1, rda=0, rx_data unchanged; rd_ack -> framing_err=0.
REQ-033 Frames 0x11 then 0x22 back-to-back, no rd_ack -> rx_data=0x11, rda=1, overrun=1; rd_ack in the completion cycle of 0x22 instead -> rx_data=0x22, overrun=0.
REQ-034 rst pulsed at bit 4 of frame 0xFF, then frame 0x5A sent -> rx_data=0x5A, rda=1, no flags set.
REQ-035 Build with SPART_RX_MAJORITY_EN, a one-tick low glitch at tick 8 of a 1 bit in frame 0xFF -> rx_data=0xFF; build without it -> a 0 is received in that bit.
